// File: rtl/cla_pipe_addsub.sv
// Carry-pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per
// stage, group carry registered between stages, valid/ready handshake with global stall.
module cla_pipe_addsub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   Q,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NSTAGE = (GROUP == 0) ? 1 : WIDTH / GROUP;
    localparam int unsigned NSKEW  = (NSTAGE > 1) ? NSTAGE - 1 : 1;
    localparam int unsigned WREM   = (GROUP == 0) ? 1 : WIDTH % GROUP;

    if (GROUP < 1 || GROUP > 8 || WIDTH == 0 || WREM != 0) begin : g_bad_params
        $error("cla_pipe_addsub: WIDTH must be a nonzero multiple of GROUP, GROUP in 1..8");
    end

    // Lookahead group: returns {carry into MSB, carry out, sum}
    function automatic logic [GROUP+1:0] group_add(input logic [GROUP-1:0] a,
                                                   input logic [GROUP-1:0] b,
                                                   input logic             c0);
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             t;
        logic             pp;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < int'(GROUP); i++) begin
            t  = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                t  = t | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = t | (pp & c0);
        end
        return {c[GROUP-1], c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    logic [NSTAGE-1:0]            v_q;
    logic [NSTAGE-1:0]            c_q;
    logic [NSTAGE-1:0][WIDTH-1:0] s_q;
    logic [NSKEW-1:0][WIDTH-1:0]  a_q;
    logic [NSKEW-1:0][WIDTH-1:0]  b_q;
    logic                         ovf_q;
    logic                         zero_q;

    logic                         stall;
    logic                         accept;
    logic [NSTAGE-1:0]            v_in;
    logic [NSTAGE-1:0]            c_nx;
    logic [NSTAGE-1:0][WIDTH-1:0] s_nx;
    logic [NSKEW-1:0][WIDTH-1:0]  a_nx;
    logic [NSKEW-1:0][WIDTH-1:0]  b_nx;
    logic                         cm_last;
    logic [WIDTH-1:0]             a_cur;
    logic [WIDTH-1:0]             b_cur;
    logic [WIDTH-1:0]             s_cur;
    logic                         c_cur;
    logic [GROUP+1:0]             grp;

    assign out_valid = v_q[NSTAGE-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = rst || !stall;
    assign accept    = in_valid && in_ready && !rst;
    assign Q         = {c_q[NSTAGE-1], s_q[NSTAGE-1]};
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // Per-stage group resolution; subtract folds into inverted B and inverted carry-in
    always_comb begin
        v_in    = '0;
        c_nx    = '0;
        s_nx    = '0;
        a_nx    = '0;
        b_nx    = '0;
        cm_last = 1'b0;
        a_cur   = '0;
        b_cur   = '0;
        s_cur   = '0;
        c_cur   = 1'b0;
        grp     = '0;
        for (int k = 0; k < int'(NSTAGE); k++) begin
            if (k == 0) begin
                a_cur   = A;
                b_cur   = B ^ {WIDTH{sub}};
                c_cur   = Cin ^ sub;
                s_cur   = '0;
                v_in[k] = accept;
            end else begin
                a_cur   = a_q[k-1];
                b_cur   = b_q[k-1];
                c_cur   = c_q[k-1];
                s_cur   = s_q[k-1];
                v_in[k] = v_q[k-1];
            end
            grp = group_add(a_cur[k*GROUP +: GROUP], b_cur[k*GROUP +: GROUP], c_cur);
            s_nx[k]                  = s_cur;
            s_nx[k][k*GROUP +: GROUP] = grp[GROUP-1:0];
            c_nx[k]                  = grp[GROUP];
            if (k == int'(NSTAGE) - 1) cm_last = grp[GROUP+1];
            if (k < int'(NSTAGE) - 1) begin
                a_nx[k] = a_cur;
                b_nx[k] = b_cur;
            end
        end
    end

    // Data registers only load with a valid beat so bubbles leave outputs untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            c_q    <= '0;
            s_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!stall) begin
            v_q <= v_in;
            for (int k = 0; k < int'(NSTAGE); k++) begin
                if (v_in[k]) begin
                    s_q[k] <= s_nx[k];
                    c_q[k] <= c_nx[k];
                end
            end
            for (int k = 0; k < int'(NSTAGE) - 1; k++) begin
                if (v_in[k]) begin
                    a_q[k] <= a_nx[k];
                    b_q[k] <= b_nx[k];
                end
            end
            if (v_in[NSTAGE-1]) begin
                ovf_q  <= cm_last ^ c_nx[NSTAGE-1];
                zero_q <= ~|s_nx[NSTAGE-1];
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub (WIDTH=16, GROUP=4, latency 4).
module tb_cla_pipe_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] Q;
    logic        ovf;
    logic        zero;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [16:0] q;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs [10];

    cla_pipe_addsub #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Q(Q), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    // One beat in, wait (bounded) for its result, check latency and value
    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        @(negedge clk);
        A = v.a; B = v.b; Cin = v.cin; sub = v.sub; in_valid = 1'b1;
        check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'd4);
        check({nm, "_q"}, 32'(Q), 32'(v.q));
        check({nm, "_ovf"}, 32'(ovf), 32'(v.ovf));
        check({nm, "_zero"}, 32'(zero), 32'(v.zero));
    endtask

    task automatic bp_test();
        int idx = 0;
        int stall_left = 0;
        bit first = 1'b0;
        bit dup = 1'b0;
        logic [16:0] held = '0;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 1; i <= 8; i++) begin
                    int w = 0;
                    @(negedge clk);
                    A = 16'(i); B = 16'(i); Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
                    while (!in_ready && w < 20) begin
                        @(negedge clk);
                        w++;
                    end
                    @(posedge clk);
                end
                #1 in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 80 && idx < 8; c++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid && !first) begin
                        first      = 1'b1;
                        stall_left = 3;
                        held       = Q;
                    end
                    if (stall_left > 0) begin
                        out_ready = 1'b0;
                        #1;
                        check("bp_in_ready_stall", 32'(in_ready), 32'd0);
                        if (stall_left != 3) check("bp_q_hold", 32'(Q), 32'(held));
                        stall_left--;
                    end else begin
                        out_ready = 1'b1;
                        #1;
                        check("bp_in_ready", 32'(in_ready), 32'd1);
                        if (out_valid) begin
                            check("bp_result", 32'(Q), 32'(2 * (idx + 1)));
                            idx++;
                        end
                    end
                end
            end
        join
        check("bp_count", 32'(idx), 32'd8);
        out_ready = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1 if (out_valid) dup = 1'b1;
        end
        check("bp_no_dup", 32'(dup), 32'd0);
    endtask

    task automatic reset_test();
        bit stale = 1'b0;
        vec_t v;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            A = 16'h0100 + 16'(i); B = 16'h0200; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b1; A = 16'h1111; B = 16'h2222;
        rst = 1'b1;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(Q), 32'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1 if (out_valid) stale = 1'b1;
        end
        check("rst_no_stale", 32'(stale), 32'd0);
        v = '{16'h0F0F, 16'h0101, 1'b0, 1'b0, 17'h01010, 1'b0, 1'b0};
        run_vec(v, "rst_new");
    endtask

    initial begin
        vecs[0] = '{16'h0005, 16'h0007, 1'b0, 1'b0, 17'h0000C, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b1, 1'b0, 17'h08001, 1'b1, 1'b0};
        vecs[3] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 17'h0FFFD, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1, 1'b0};
        vecs[5] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 17'h10000, 1'b0, 1'b1};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 17'h0FFFF, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000, 1'b1, 1'b1};
        vecs[8] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, 1'b0, 1'b0};
        vecs[9] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h00100, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_q", 32'(Q), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_zero", 32'(zero), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        @(posedge clk);
        bp_test();
        reset_test();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, carry-pipelined carry-lookahead adder/subtractor for the calculator datapath. Successor to the fixed 4-bit CLA.
- The WIDTH-bit operation is split into GROUP-bit lookahead groups. One group resolves per pipeline stage, and the group carry is registered between stages.
- Adds a subtract mode, status flags and a valid/ready handshake with backpressure. Throughput is one operation per cycle.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of GROUP.
- GROUP, 4, bits per lookahead group and per pipeline stage. Legal range 1..8. An illegal WIDTH/GROUP combination is an elaboration error.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- Cin  in  1  carry-in (add) / borrow-in (sub)
- sub  in  1  0 = A+B+Cin, 1 = A-B-Cin
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- Q  out  WIDTH+1  {carry_out, sum}
- ovf  out  1  signed two's-complement overflow
- zero  out  1  sum (low WIDTH bits) == 0

Behaviour:
- NSTAGE = WIDTH/GROUP. Latency: a beat accepted on edge n presents at the outputs after edge n+NSTAGE-1, i.e. NSTAGE cycles, provided there is no stall.
- Accept condition: in_valid && in_ready at a rising edge. Operands and mode are captured only on accept.
- Subtract: B is inverted into the lookahead and the group-0 carry-in is ~Cin, so the result is A + ~B + ~Cin = A - B - Cin.
- Q[WIDTH] in sub mode: 1 = no borrow, 0 = borrow.
- Stage k computes the g/p terms and sum for bits [k*GROUP +: GROUP] using the carry registered by stage k-1.
- Completed low sum bits travel forward with the beat. Unconsumed upper operand bits are skewed forward unchanged.
- ovf = carry into MSB XOR carry out of MSB, evaluated in the final stage.
- zero = ~|Q[WIDTH-1:0].
- Backpressure: stall = out_valid && !out_ready. On stall, every stage holds, and in_ready = !stall (combinational).
- No bubbles are inserted and no beats are dropped or duplicated. Order is preserved.
- Empty stages (valid=0) do not block upstream: a bubble is overwritten when no stall is active.
- Each pipeline stage carries a valid bit. out_valid equals the final stage's valid bit.
- Q, ovf and zero hold their value while out_valid && !out_ready. They are don't-care when out_valid=0, but the implementation must drive them to 0 after reset.
- Reset (synchronous, active-high):
  - All stage valid bits, out_valid, Q, ovf and zero go to 0 on the edge where rst=1.
  - in_ready is 1 during and after reset.
  - Beats in flight when reset asserts are discarded, and no stale result appears after rst deasserts.
  - A beat presented with in_valid during a rst=1 cycle is not accepted.
- Simultaneous accept and output handoff in the same cycle (out_ready=1, pipeline full) is legal and sustains one beat per cycle.
- GROUP = WIDTH degenerates to a single stage with 1-cycle latency. The same handshake rules apply.

Test Plan (WIDTH=16, GROUP=4, so latency is 4):
1. Add, rst released, out_ready=1: A=0x0005, B=0x0007, Cin=0, sub=0. Required 4 cycles after accept: out_valid=1, Q=0x0000C, ovf=0, zero=0.
2. Add carry wrap: A=0xFFFF, B=0x0001, Cin=0. Required: Q=0x10000, zero=1, ovf=0.
3. Add signed overflow: A=0x7FFF, B=0x0001, Cin=1. Required: Q=0x08001, ovf=1, zero=0.
4. Sub with borrow-in: A=0x0003, B=0x0005, Cin=1, sub=1. Required: Q=0x0FFFD (borrow, Q[16]=0), ovf=0. Also A=0x8000, B=0x0001, Cin=0, sub=1. Required: Q=0x17FFF, ovf=1.
5. Backpressure: 8 back-to-back beats A=i, B=i (i=1..8). Hold out_ready=0 for 3 cycles once the first result appears. Required:
   - in_ready=0 exactly during the stall.
   - Results 2,4,...,16 are delivered in order, with no loss or duplication.
   - Q is held stable during the stall.
6. Reset mid-flight: accept 2 beats, then assert rst for 1 cycle. Required: out_valid=0 and Q=0 from the next cycle. No result for the flushed beats ever appears. A new beat after release returns the correct result after 4 cycles.
